mul24_share_ctrl: RTL
=====================

# mul24_share_ctrl

Two-port arbiter and pipeline sequencer that shares a single `mul_24bit` mantissa multiplier between two requesters inside the single-precision FP multiplier.

- Typical requesters are two FP multiply lanes, e.g. main datapath and a divide/sqrt iteration unit.
- Each requester issues 24-bit unsigned mantissa pairs through a valid/ready handshake.
- Grant is round-robin, so neither requester starves.
- Operands and products pass through two register stages around the combinational multiplier.
- Each 48-bit product is returned on a single response channel, tagged with the requester id, with full backpressure.

## Interface
- PRIO_INIT, 0, requester (0 or 1) holding round-robin priority after reset.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  2  bit i: requester i presents operands.
- req_ready  output  2  bit i: operands of requester i accepted this cycle when also valid.
- req_a0, req_b0  input  24 each  requester 0 mantissas (unsigned, hidden bit included).
- req_a1, req_b1  input  24 each  requester 1 mantissas.
- rsp_valid  output  1  product available.
- rsp_ready  input  1  consumer accepts product.
- rsp_id  output  1  requester that issued the product.
- rsp_y  output  48  unsigned product a*b.
- busy  output  1  any pipeline stage occupied.

## Operation
**Datapath**
- S1 register holds a, b, id and s1_valid.
- One `mul_24bit` instance computes the product combinationally from the S1 operands.
- S2 register holds y, id and s2_valid, and drives rsp_y, rsp_id and rsp_valid directly.

**Advance rules**
- adv2 = ~s2_valid | rsp_ready. S2 loads from S1 (y, id, s2_valid <= s1_valid) when adv2.
- load1 = ~s1_valid | adv2. S1 loads when load1. s1_valid <= 1 if a handshake occurred, else 0.
- When a stage does not advance, it holds all of its contents.

**Arbitration**
- ptr is one bit and names the requester with priority.
- req_ready[i] = load1 & ~(req_valid[1-i] & ptr==1-i).
- Handshake on i = req_valid[i] & req_ready[i]; at most one handshake per cycle.
- On a handshake from i, ptr <= 1-i. Otherwise ptr holds, including when req_ready is low due to a stall.

**Other rules**
- A requester may raise valid without waiting for ready. Once valid is asserted, operands must stay stable until the handshake; the bench checks this, the RTL does not enforce it.
- Arithmetic: exact unsigned 24x24 -> 48 product, no rounding or truncation. Normalisation is done downstream.
- busy = s1_valid | s2_valid.

**Reset (asynchronous assert; applies mid-operation)**
- s1_valid = s2_valid = 0, ptr = PRIO_INIT.
- S1 and S2 data and id registers are cleared to 0.
- Outputs: rsp_valid=0, rsp_id=0, rsp_y=0, busy=0.
- While rst=1, req_ready=0.
- In-flight products are discarded; no response is produced for them.
- First handshake is possible in the first cycle after rst deasserts.

## Timing
- Latency: handshake at edge N gives rsp_valid=1 with the product after edge N+1, i.e. visible in cycle N+1.
- Throughput: one product per cycle while rsp_ready=1.
- Backpressure, with rsp_valid=1 and rsp_ready=0:
  - S2 holds.
  - S1 holds if occupied. With S1 full, req_ready=2'b00.
  - With S1 empty, one more handshake is taken, filling S1. Maximum of two products in flight.
- rsp_valid must not drop, and rsp_y/rsp_id must not change, until the response handshake.
- Simultaneous response handshake and new request handshake in the same cycle are allowed with no bubble.
- Critical path: S1 -> mul_24bit (Wallace tree plus 42-bit RCA) -> S2. No other logic sits in this path.

## Test plan
- Single op: rst, then req0 a=0xFFFFFF, b=0xFFFFFF, rsp_ready=1 -> rsp_valid one cycle after the handshake, rsp_y=0xFFFFFE000001, rsp_id=0, busy drops the next cycle.
- Contention: both valid continuously with PRIO_INIT=0, req0 0x800000*0x800000, req1 0xC00000*0xA00000 -> grants alternate 0,1,0,1. Responses alternate y=0x400000000000 (id 0) and y=0x780000000000 (id 1), one per cycle.
- Backpressure: stream on req1, rsp_ready=0 for 5 cycles -> exactly 2 handshakes, then req_ready=0. rsp_y/rsp_id stable throughout. On release, in-order drain with no loss or duplication.
- Idle priority: req1 issues alone 3 times, then both valid -> req0 granted first (ptr=0 after the last req1 grant).
- Reset mid-flight: 2 ops in flight, rst pulsed asynchronously between edges -> rsp_valid, busy and rsp_y go 0 immediately. No stale response after release. ptr=PRIO_INIT.
- Random: 10k random operand pairs, random valid/ready toggling -> every product matches a 48-bit golden model, per-id order preserved, no requester waits more than 1 competing grant.

Source files
------------

// File: rtl/mul24_share_ctrl_if.sv
// mul24_share_ctrl_if
//   Request and response bus of the shared 24x24 mantissa multiplier.
//   master: requesters and response consumer (drive req_*, rsp_ready).
//   slave : mul24_share_ctrl (drives req_ready and rsp_*).
//   req_valid/req_ready : per-requester handshake, bit i = requester i
//   req_a0/req_b0       : requester 0 mantissas (24b, hidden bit included)
//   req_a1/req_b1       : requester 1 mantissas
//   rsp_valid/rsp_ready : response handshake
//   rsp_id              : requester that issued the product
//   rsp_y               : 48b unsigned product
interface mul24_share_ctrl_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [23:0] req_a0;
    logic [23:0] req_b0;
    logic [23:0] req_a1;
    logic [23:0] req_b1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [47:0] rsp_y;

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_y
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_y
    );
endinterface

// File: rtl/mul24_share_ctrl.sv
// mul24_share_ctrl
//   Shares one combinational 24x24 mantissa multiplier between two
//   requesters. Round-robin grant, S1 operand register -> mul_24bit ->
//   S2 product register, one tagged response channel with backpressure.
//   Ports:
//     clk  : clock, rising edge
//     rst  : asynchronous active-high reset
//     bus  : mul24_share_ctrl_if.slave (request/response handshakes)
//     busy : any pipeline stage occupied
//   Parameter PRIO_INIT: requester holding priority after reset.

// Exact unsigned 24x24 -> 48 product, purely combinational.
module mul_24bit (
    input  logic [23:0] a,
    input  logic [23:0] b,
    output logic [47:0] y
);
    assign y = 48'(a) * 48'(b);
endmodule

module mul24_share_ctrl #(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    mul24_share_ctrl_if.slave   bus,
    output logic                busy
);
    logic        s1_valid;
    logic [23:0] s1_a;
    logic [23:0] s1_b;
    logic        s1_id;
    logic        s2_valid;
    logic [47:0] s2_y;
    logic        s2_id;
    logic [47:0] prod;
    logic        ptr;
    logic        adv2;
    logic        load1;
    logic [1:0]  ready;
    logic [1:0]  hs;

    // A requester is held off only when the other one is also valid and
    // owns priority, so at most one handshake can happen per cycle.
    always_comb begin
        adv2     = ~s2_valid | bus.rsp_ready;
        load1    = ~s1_valid | adv2;
        ready[0] = ~rst & load1 & ~(bus.req_valid[1] & ptr);
        ready[1] = ~rst & load1 & ~(bus.req_valid[0] & ~ptr);
        hs       = bus.req_valid & ready;
    end

    mul_24bit u_mul (
        .a (s1_a),
        .b (s1_b),
        .y (prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= PRIO_INIT;
        end else if (hs[0]) begin
            ptr <= 1'b1;
        end else if (hs[1]) begin
            ptr <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= 1'b0;
        end else if (load1) begin
            s1_valid <= |hs;
            if (hs[1]) begin
                s1_a  <= bus.req_a1;
                s1_b  <= bus.req_b1;
                s1_id <= 1'b1;
            end else if (hs[0]) begin
                s1_a  <= bus.req_a0;
                s1_b  <= bus.req_b0;
                s1_id <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_y     <= '0;
            s2_id    <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            s2_y     <= prod;
            s2_id    <= s1_id;
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = s2_valid;
    assign bus.rsp_y     = s2_y;
    assign bus.rsp_id    = s2_id;
    assign busy          = s1_valid | s2_valid;
endmodule
